// File: rtl/age_ordered_rs_if.sv
`default_nettype none
// ============================================================================
// Module      : age_ordered_rs_if
// Description : Dispatch, CDB broadcast and issue bundle of the reservation
//               station.
// Revision    : 1.0 - initial release
// ============================================================================
interface age_ordered_rs_if #(
   parameter int SIZE      = 8,
   parameter int TAG_W     = 4,
   parameter int WIDTH     = 32,
   parameter int OP_W      = 4,
   parameter int CDB_PORTS = 2
);
   localparam int c_cnt_w = $clog2(SIZE + 1);

   logic                       flush;
   logic                       in_valid;
   logic                       in_ready;
   logic [TAG_W-1:0]           in_tag;
   logic [OP_W-1:0]            in_op;
   logic                       in_busy1;
   logic                       in_busy2;
   logic [TAG_W-1:0]           in_q1;
   logic [TAG_W-1:0]           in_q2;
   logic [WIDTH-1:0]           in_v1;
   logic [WIDTH-1:0]           in_v2;
   logic [CDB_PORTS-1:0]       cdb_valid;
   logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
   logic [CDB_PORTS*WIDTH-1:0] cdb_data;
   logic                       issue_valid;
   logic                       issue_ready;
   logic [TAG_W-1:0]           issue_tag;
   logic [OP_W-1:0]            issue_op;
   logic [WIDTH-1:0]           issue_v1;
   logic [WIDTH-1:0]           issue_v2;
   logic [c_cnt_w-1:0]         num_available;

   modport master (
      output flush, in_valid, in_tag, in_op, in_busy1, in_busy2, in_q1, in_q2,
             in_v1, in_v2, cdb_valid, cdb_tag, cdb_data, issue_ready,
      input  in_ready, issue_valid, issue_tag, issue_op, issue_v1, issue_v2,
             num_available
   );

   modport slave (
      input  flush, in_valid, in_tag, in_op, in_busy1, in_busy2, in_q1, in_q2,
             in_v1, in_v2, cdb_valid, cdb_tag, cdb_data, issue_ready,
      output in_ready, issue_valid, issue_tag, issue_op, issue_v1, issue_v2,
             num_available
   );
endinterface
`default_nettype wire

// File: rtl/age_ordered_rs.sv
`default_nettype none
// ============================================================================
// Module      : age_ordered_rs
// Description : Reservation station with age-matrix oldest-first issue and
//               multi-port CDB wakeup, including dispatch-cycle bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module age_ordered_rs #(
   parameter int SIZE      = 8,
   parameter int TAG_W     = 4,
   parameter int WIDTH     = 32,
   parameter int OP_W      = 4,
   parameter int CDB_PORTS = 2
) (
   input  wire logic       clk,
   input  wire logic       rst,
   age_ordered_rs_if.slave rs
);
   localparam int c_idx_w = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int c_cnt_w = $clog2(SIZE + 1);

   logic [SIZE-1:0]            r_valid;
   logic [SIZE-1:0]            r_busy1;
   logic [SIZE-1:0]            r_busy2;
   logic [SIZE-1:0][SIZE-1:0]  r_older;
   logic [TAG_W-1:0]           r_tag [SIZE];
   logic [OP_W-1:0]            r_op  [SIZE];
   logic [TAG_W-1:0]           r_q1  [SIZE];
   logic [TAG_W-1:0]           r_q2  [SIZE];
   logic [WIDTH-1:0]           r_v1  [SIZE];
   logic [WIDTH-1:0]           r_v2  [SIZE];

   logic [WIDTH:0]             w_wk1 [SIZE];
   logic [WIDTH:0]             w_wk2 [SIZE];
   logic [WIDTH:0]             w_in_wk1;
   logic [WIDTH:0]             w_in_wk2;
   logic [SIZE-1:0]            w_ready;
   logic [SIZE-1:0]            w_sel;
   logic [c_idx_w-1:0]         w_alloc;
   logic [c_cnt_w-1:0]         w_count;
   logic [c_cnt_w-1:0]         w_num_avail;
   logic                       w_in_ready;
   logic                       w_dispatch;
   logic                       w_issue_valid;
   logic                       w_issue_fire;

   // Returns {hit, data}; the lowest-numbered matching port wins.
   function automatic logic [WIDTH:0] cdb_lookup(
      input logic [TAG_W-1:0]           q,
      input logic [CDB_PORTS-1:0]       vld,
      input logic [CDB_PORTS*TAG_W-1:0] tags,
      input logic [CDB_PORTS*WIDTH-1:0] data
   );
      logic [WIDTH:0] res;
      res = '0;
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
         if (vld[p] && (tags[p*TAG_W +: TAG_W] == q)) begin
            res = {1'b1, data[p*WIDTH +: WIDTH]};
         end
      end
      return res;
   endfunction

   always_comb begin
      for (int i = 0; i < SIZE; i++) begin
         w_wk1[i] = cdb_lookup(r_q1[i], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
         w_wk2[i] = cdb_lookup(r_q2[i], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
      end
      w_in_wk1 = cdb_lookup(rs.in_q1, rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
      w_in_wk2 = cdb_lookup(rs.in_q2, rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
   end

   always_comb begin
      w_alloc = '0;
      w_count = '0;
      for (int i = SIZE - 1; i >= 0; i--) begin
         if (!r_valid[i]) begin
            w_alloc = c_idx_w'(i);
         end
         w_count = w_count + c_cnt_w'(r_valid[i]);
      end
      w_num_avail = c_cnt_w'(SIZE) - w_count;
   end

   assign w_ready = r_valid & ~r_busy1 & ~r_busy2;

   // An entry is selected when no other ready entry is older than it.
   always_comb begin
      for (int i = 0; i < SIZE; i++) begin
         w_sel[i] = w_ready[i];
         for (int j = 0; j < SIZE; j++) begin
            if (w_ready[j] && r_older[j][i]) begin
               w_sel[i] = 1'b0;
            end
         end
      end
   end

   assign w_in_ready    = (w_num_avail != '0);
   assign w_dispatch    = rs.in_valid && w_in_ready && !rs.flush;
   assign w_issue_valid = (|w_ready) && !rs.flush;
   assign w_issue_fire  = w_issue_valid && rs.issue_ready;

   always_comb begin
      rs.issue_tag = '0;
      rs.issue_op  = '0;
      rs.issue_v1  = '0;
      rs.issue_v2  = '0;
      for (int i = 0; i < SIZE; i++) begin
         if (w_issue_valid && w_sel[i]) begin
            rs.issue_tag = r_tag[i];
            rs.issue_op  = r_op[i];
            rs.issue_v1  = r_v1[i];
            rs.issue_v2  = r_v2[i];
         end
      end
   end

   assign rs.issue_valid   = w_issue_valid;
   assign rs.in_ready      = w_in_ready;
   assign rs.num_available = w_num_avail;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
         r_busy1 <= '0;
         r_busy2 <= '0;
         r_older <= '0;
         for (int i = 0; i < SIZE; i++) begin
            r_tag[i] <= '0;
            r_op[i]  <= '0;
            r_q1[i]  <= '0;
            r_q2[i]  <= '0;
            r_v1[i]  <= '0;
            r_v2[i]  <= '0;
         end
      end else if (rs.flush) begin
         r_valid <= '0;
      end else begin
         for (int i = 0; i < SIZE; i++) begin
            if (r_valid[i] && r_busy1[i] && w_wk1[i][WIDTH]) begin
               r_busy1[i] <= 1'b0;
               r_v1[i]    <= w_wk1[i][WIDTH-1:0];
            end
            if (r_valid[i] && r_busy2[i] && w_wk2[i][WIDTH]) begin
               r_busy2[i] <= 1'b0;
               r_v2[i]    <= w_wk2[i][WIDTH-1:0];
            end
            if (w_issue_fire && w_sel[i]) begin
               r_valid[i] <= 1'b0;
            end
         end
         // The allocated slot is free in registered state, so it never
         // collides with the wakeup or issue updates above.
         if (w_dispatch) begin
            r_valid[w_alloc] <= 1'b1;
            r_tag[w_alloc]   <= rs.in_tag;
            r_op[w_alloc]    <= rs.in_op;
            r_q1[w_alloc]    <= rs.in_q1;
            r_q2[w_alloc]    <= rs.in_q2;
            r_busy1[w_alloc] <= rs.in_busy1 && !w_in_wk1[WIDTH];
            r_busy2[w_alloc] <= rs.in_busy2 && !w_in_wk2[WIDTH];
            r_v1[w_alloc]    <= (rs.in_busy1 && w_in_wk1[WIDTH]) ?
                                w_in_wk1[WIDTH-1:0] : rs.in_v1;
            r_v2[w_alloc]    <= (rs.in_busy2 && w_in_wk2[WIDTH]) ?
                                w_in_wk2[WIDTH-1:0] : rs.in_v2;
            for (int j = 0; j < SIZE; j++) begin
               r_older[j][w_alloc] <= r_valid[j];
               r_older[w_alloc][j] <= 1'b0;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_age_ordered_rs.sv
`default_nettype none
// ============================================================================
// Module      : tb_age_ordered_rs
// Description : Directed and randomized bench for age_ordered_rs against an
//               age-sequence-number reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_age_ordered_rs;
   localparam int SIZE      = 8;
   localparam int TAG_W     = 4;
   localparam int WIDTH     = 32;
   localparam int OP_W      = 4;
   localparam int CDB_PORTS = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   age_ordered_rs_if #(.SIZE(SIZE), .TAG_W(TAG_W), .WIDTH(WIDTH), .OP_W(OP_W),
                       .CDB_PORTS(CDB_PORTS)) bus ();

   age_ordered_rs #(.SIZE(SIZE), .TAG_W(TAG_W), .WIDTH(WIDTH), .OP_W(OP_W),
                    .CDB_PORTS(CDB_PORTS)) dut (
      .clk (clk),
      .rst (rst),
      .rs  (bus.slave)
   );

   // Reference model: entries carry a dispatch sequence number for age.
   bit               m_valid [SIZE];
   bit               m_b1    [SIZE];
   bit               m_b2    [SIZE];
   logic [TAG_W-1:0] m_tag   [SIZE];
   logic [OP_W-1:0]  m_op    [SIZE];
   logic [TAG_W-1:0] m_q1    [SIZE];
   logic [TAG_W-1:0] m_q2    [SIZE];
   logic [WIDTH-1:0] m_v1    [SIZE];
   logic [WIDTH-1:0] m_v2    [SIZE];
   int unsigned      m_seq   [SIZE];
   int unsigned      seq_ctr = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic void cdb_match(input logic [TAG_W-1:0] q, output bit hit,
                                     output logic [WIDTH-1:0] d);
      hit = 1'b0;
      d   = '0;
      for (int p = 0; p < CDB_PORTS; p++) begin
         if (!hit && bus.cdb_valid[p] && bus.cdb_tag[p*TAG_W +: TAG_W] == q) begin
            hit = 1'b1;
            d   = bus.cdb_data[p*WIDTH +: WIDTH];
         end
      end
   endfunction

   function automatic int oldest_ready();
      int best = -1;
      for (int i = 0; i < SIZE; i++) begin
         if (m_valid[i] && !m_b1[i] && !m_b2[i]) begin
            if (best < 0 || m_seq[i] < m_seq[best]) best = i;
         end
      end
      return best;
   endfunction

   task automatic model_step(input int idx, input bit iv, input int avail);
      int               slot;
      bit               h;
      logic [WIDTH-1:0] d;
      if (bus.flush) begin
         for (int i = 0; i < SIZE; i++) m_valid[i] = 1'b0;
         return;
      end
      slot = -1;
      for (int i = 0; i < SIZE; i++) if (!m_valid[i] && slot < 0) slot = i;
      for (int i = 0; i < SIZE; i++) begin
         if (m_valid[i] && m_b1[i]) begin
            cdb_match(m_q1[i], h, d);
            if (h) begin m_b1[i] = 1'b0; m_v1[i] = d; end
         end
         if (m_valid[i] && m_b2[i]) begin
            cdb_match(m_q2[i], h, d);
            if (h) begin m_b2[i] = 1'b0; m_v2[i] = d; end
         end
      end
      if (iv && bus.issue_ready) m_valid[idx] = 1'b0;
      if (bus.in_valid && avail > 0) begin
         m_valid[slot] = 1'b1;
         m_seq[slot]   = seq_ctr++;
         m_tag[slot]   = bus.in_tag;
         m_op[slot]    = bus.in_op;
         m_q1[slot]    = bus.in_q1;
         m_q2[slot]    = bus.in_q2;
         m_b1[slot]    = bus.in_busy1;
         m_b2[slot]    = bus.in_busy2;
         m_v1[slot]    = bus.in_v1;
         m_v2[slot]    = bus.in_v2;
         if (bus.in_busy1) begin
            cdb_match(bus.in_q1, h, d);
            if (h) begin m_b1[slot] = 1'b0; m_v1[slot] = d; end
         end
         if (bus.in_busy2) begin
            cdb_match(bus.in_q2, h, d);
            if (h) begin m_b2[slot] = 1'b0; m_v2[slot] = d; end
         end
      end
   endtask

   // Inputs change just after posedge, so at negedge they equal what the
   // next posedge samples.
   always @(negedge clk) begin : p_cmp
      int idx;
      int avail;
      bit e_iv;
      if (!rst) for (int i = 0; i < SIZE; i++) m_valid[i] = 1'b0;
      idx   = oldest_ready();
      avail = SIZE;
      for (int i = 0; i < SIZE; i++) if (m_valid[i]) avail--;
      e_iv = (idx >= 0) && !bus.flush;
      check("num_available", 64'(bus.num_available), 64'(avail));
      check("in_ready", 64'(bus.in_ready), 64'(avail != 0));
      check("issue_valid", 64'(bus.issue_valid), 64'(e_iv));
      if (e_iv) begin
         check("issue_tag", 64'(bus.issue_tag), 64'(m_tag[idx]));
         check("issue_op",  64'(bus.issue_op),  64'(m_op[idx]));
         check("issue_v1",  64'(bus.issue_v1),  64'(m_v1[idx]));
         check("issue_v2",  64'(bus.issue_v2),  64'(m_v2[idx]));
      end else begin
         check("issue_tag_idle", 64'(bus.issue_tag), 64'd0);
         check("issue_op_idle",  64'(bus.issue_op),  64'd0);
         check("issue_v1_idle",  64'(bus.issue_v1),  64'd0);
         check("issue_v2_idle",  64'(bus.issue_v2),  64'd0);
      end
      if (rst) model_step(idx, e_iv, avail);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_busy1  = 1'b0;
      bus.in_busy2  = 1'b0;
      bus.cdb_valid = '0;
   endtask

   task automatic disp(input int tag, input bit b1, input int q1, input int v1,
                       input bit b2, input int q2, input int v2);
      bus.in_valid = 1'b1;
      bus.in_tag   = TAG_W'(tag);
      bus.in_op    = OP_W'(tag + 1);
      bus.in_busy1 = b1;
      bus.in_q1    = TAG_W'(q1);
      bus.in_v1    = WIDTH'(v1);
      bus.in_busy2 = b2;
      bus.in_q2    = TAG_W'(q2);
      bus.in_v2    = WIDTH'(v2);
   endtask

   task automatic cdb(input int p, input int tag, input int data);
      bus.cdb_valid[p]                = 1'b1;
      bus.cdb_tag[p*TAG_W +: TAG_W]   = TAG_W'(tag);
      bus.cdb_data[p*WIDTH +: WIDTH]  = WIDTH'(data);
   endtask

   initial begin
      idle();
      bus.issue_ready = 1'b0;
      bus.in_tag = '0; bus.in_op = '0; bus.in_q1 = '0; bus.in_q2 = '0;
      bus.in_v1 = '0; bus.in_v2 = '0; bus.cdb_tag = '0; bus.cdb_data = '0;
      repeat (3) cyc();
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_avail", 64'(bus.num_available), 64'd8);
      check("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
      rst = 1'b1;
      cyc();

      // Single ready dispatch: issuable the next cycle.
      bus.in_op = 4'd2;
      disp(3, 0, 0, 5, 0, 0, 7);
      bus.in_op = 4'd2;
      cyc(); idle();
      check("d1_valid", 64'(bus.issue_valid), 64'd1);
      check("d1_tag", 64'(bus.issue_tag), 64'd3);
      check("d1_op", 64'(bus.issue_op), 64'd2);
      check("d1_v1", 64'(bus.issue_v1), 64'd5);
      check("d1_v2", 64'(bus.issue_v2), 64'd7);
      check("d1_avail", 64'(bus.num_available), 64'd7);
      bus.issue_ready = 1'b1;
      cyc();
      bus.issue_ready = 1'b0;
      check("d1_avail_back", 64'(bus.num_available), 64'd8);

      // Age order among ready entries.
      for (int t = 1; t <= 3; t++) begin disp(t, 0, 0, t, 0, 0, 0); cyc(); end
      idle();
      check("age_first", 64'(bus.issue_tag), 64'd1);
      bus.issue_ready = 1'b1;
      cyc(); check("age_second", 64'(bus.issue_tag), 64'd2);
      cyc(); check("age_third", 64'(bus.issue_tag), 64'd3);
      cyc(); check("age_empty", 64'(bus.issue_valid), 64'd0);
      bus.issue_ready = 1'b0;

      // Oldest entry waiting on tag 9.
      disp(1, 1, 9, 0, 0, 0, 0); cyc();
      disp(2, 0, 0, 2, 0, 0, 0); cyc();
      disp(3, 0, 0, 3, 0, 0, 0); cyc();
      idle();
      bus.issue_ready = 1'b1;
      check("busy_first", 64'(bus.issue_tag), 64'd2);
      cyc(); check("busy_second", 64'(bus.issue_tag), 64'd3);
      cyc(); check("busy_wait", 64'(bus.issue_valid), 64'd0);
      cdb(0, 9, 'hAB);
      cyc(); idle();
      check("wake_valid", 64'(bus.issue_valid), 64'd1);
      check("wake_tag", 64'(bus.issue_tag), 64'd1);
      check("wake_v1", 64'(bus.issue_v1), 64'hAB);
      cyc(); bus.issue_ready = 1'b0;

      // Dispatch-cycle bypass on port 1.
      disp(4, 0, 0, 1, 1, 6, 0);
      cdb(1, 6, 'h1234);
      cyc(); idle();
      check("bypass_valid", 64'(bus.issue_valid), 64'd1);
      check("bypass_v2", 64'(bus.issue_v2), 64'h1234);
      bus.issue_ready = 1'b1; cyc(); bus.issue_ready = 1'b0;

      // A younger entry becoming ready does not displace the selection.
      disp(4, 0, 0, 4, 0, 0, 0); cyc();
      disp(5, 1, 2, 0, 0, 0, 0); cyc(); idle();
      cdb(0, 2, 'h77); cyc(); idle();
      check("hold_tag", 64'(bus.issue_tag), 64'd4);
      bus.issue_ready = 1'b1; cyc();
      check("hold_next", 64'(bus.issue_tag), 64'd5);
      cyc(); bus.issue_ready = 1'b0;

      // Fill to full, drop a ninth dispatch, then free one slot.
      for (int i = 0; i < SIZE; i++) begin disp(i, 1, 8 + i, 0, 0, 0, 0); cyc(); end
      idle();
      check("full_ready", 64'(bus.in_ready), 64'd0);
      check("full_avail", 64'(bus.num_available), 64'd0);
      disp(15, 0, 0, 0, 0, 0, 0); cyc(); idle();
      check("full_drop_avail", 64'(bus.num_available), 64'd0);
      check("full_drop_iv", 64'(bus.issue_valid), 64'd0);
      cdb(0, 11, 'h55); cyc(); idle();
      check("full_wake_tag", 64'(bus.issue_tag), 64'd3);
      check("full_wake_ready", 64'(bus.in_ready), 64'd0);
      bus.issue_ready = 1'b1; cyc(); bus.issue_ready = 1'b0;
      check("full_after_ready", 64'(bus.in_ready), 64'd1);
      check("full_after_avail", 64'(bus.num_available), 64'd1);
      bus.flush = 1'b1; cyc(); idle();

      // Two ports wake both operands; same-tag conflict favours port 0.
      disp(6, 1, 4, 0, 1, 5, 0); cyc(); idle();
      cdb(0, 4, 'hA); cdb(1, 5, 'hB); cyc(); idle();
      check("dual_valid", 64'(bus.issue_valid), 64'd1);
      check("dual_v1", 64'(bus.issue_v1), 64'hA);
      check("dual_v2", 64'(bus.issue_v2), 64'hB);
      bus.issue_ready = 1'b1; cyc(); bus.issue_ready = 1'b0;
      disp(7, 1, 7, 0, 0, 0, 0); cyc(); idle();
      cdb(0, 7, 'h11); cdb(1, 7, 'h22); cyc(); idle();
      check("prio_v1", 64'(bus.issue_v1), 64'h11);
      bus.issue_ready = 1'b1; cyc(); bus.issue_ready = 1'b0;

      // Flush with a concurrent dispatch.
      for (int t = 0; t < 5; t++) begin disp(t, 0, 0, t, 0, 0, 0); cyc(); end
      disp(9, 0, 0, 9, 0, 0, 0);
      bus.flush = 1'b1;
      #1 check("flush_gate_iv", 64'(bus.issue_valid), 64'd0);
      cyc(); idle();
      check("flush_avail", 64'(bus.num_available), 64'd8);
      check("flush_iv", 64'(bus.issue_valid), 64'd0);

      // Asynchronous reset mid-stream.
      for (int t = 0; t < 3; t++) begin disp(t, 0, 0, t, 0, 0, 0); cyc(); end
      idle();
      #2 rst = 1'b0;
      #1;
      check("arst_avail", 64'(bus.num_available), 64'd8);
      check("arst_ready", 64'(bus.in_ready), 64'd1);
      check("arst_iv", 64'(bus.issue_valid), 64'd0);
      check("arst_tag", 64'(bus.issue_tag), 64'd0);
      cyc(); cyc();
      rst = 1'b1;
      cyc();

      // Randomized traffic; the negedge process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         idle();
         bus.flush       = ($urandom_range(0, 63) == 0);
         bus.in_valid    = ($urandom_range(0, 9) < 6);
         bus.in_tag      = TAG_W'($urandom);
         bus.in_op       = OP_W'($urandom);
         bus.in_busy1    = $urandom_range(0, 1) == 1;
         bus.in_busy2    = $urandom_range(0, 2) == 0;
         bus.in_q1       = TAG_W'($urandom_range(0, 7));
         bus.in_q2       = TAG_W'($urandom_range(0, 7));
         bus.in_v1       = $urandom;
         bus.in_v2       = $urandom;
         bus.issue_ready = $urandom_range(0, 1) == 1;
         for (int p = 0; p < CDB_PORTS; p++) begin
            if ($urandom_range(0, 2) == 0) cdb(p, $urandom_range(0, 7), $urandom);
         end
         cyc();
      end
      idle();
      bus.issue_ready = 1'b0;
      repeat (2) cyc();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/age_ordered_rs.md
# age_ordered_rs

Parametrised reservation station with oldest-first issue, tag-matched multi-port CDB wakeup and valid/ready handshakes on both sides. It sits between the ROB/regfile dispatch stage and one functional unit (ALU, CMP or ACU). An entry is freed when it issues to the unit, not on a later broadcast. Operand capture from the CDB is bypassed on the dispatch cycle so that no wakeup is missed.

## Interface
- SIZE, 8, number of entries (≥2)
- TAG_W, 4, ROB tag width
- WIDTH, 32, operand/data width
- OP_W, 4, opaque opcode field carried to the unit
- CDB_PORTS, 2, number of broadcast ports
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries
- in_valid  in  1  dispatch request
- in_ready  out  1  at least one free entry
- in_tag  in  TAG_W  ROB tag of dispatched instruction
- in_op  in  OP_W  opcode
- in_busy1 / in_busy2  in  1  operand is pending (field holds a tag)
- in_q1 / in_q2  in  TAG_W  producer tag when busy
- in_v1 / in_v2  in  WIDTH  operand value when not busy
- cdb_valid  in  CDB_PORTS  per-port broadcast valid
- cdb_tag  in  CDB_PORTS×TAG_W  broadcast tags
- cdb_data  in  CDB_PORTS×WIDTH  broadcast data
- issue_valid  out  1  an entry is ready to issue
- issue_ready  in  1  unit accepts this cycle
- issue_tag / issue_op / issue_v1 / issue_v2  out  TAG_W/OP_W/WIDTH/WIDTH  selected entry contents
- num_available  out  $clog2(SIZE+1)  count of free entries

## Operation
- Entry state: valid, tag, op, busy1/2, q1/2, v1/2, plus an SIZE×SIZE age matrix (older[j][i] = 1 means entry j is older than entry i).
- Dispatch fires when in_valid && in_ready. It allocates the lowest-index free entry k.
  - The age row and column for k are written: older[j][k] = valid[j], older[k][j] = 0.
- A dispatch with in_ready = 0 is ignored. No state changes.
- Wakeup: for each valid entry with busyN = 1, if any port p has cdb_valid[p] && cdb_tag[p] == qN:
  - vN <= cdb_data[p]
  - busyN <= 0
  - If several ports match, the lowest p wins.
- Dispatch bypass: if an incoming busy operand matches a CDB port in the dispatch cycle, the entry is written non-busy with the CDB data.
- ready[i] = valid[i] && !busy1[i] && !busy2[i], computed from registered state only.
- Select: the unique ready i with no ready j having older[j][i] = 1.
  - issue_valid = any ready && !flush.
  - The issue_* fields come from entry i.
  - All issue_* fields are 0 when issue_valid = 0.
- Issue handshake (issue_valid && issue_ready) clears valid[i] at the edge. issue_* may change only after a handshake, a flush, or a newly ready older entry.
- Dispatch and issue in the same cycle target different entries, because in_ready and the allocation slot come from registered state. A slot freed by issue is not reusable until the next cycle.
- Flush clears all valid bits. It has priority over dispatch, wakeup and issue, and a dispatch in a flush cycle is dropped.
- num_available = SIZE − popcount(valid). in_ready = (num_available != 0).

## Timing
- Reset (rst = 0, asynchronous): all valid = 0, age matrix = 0, issue_valid = 0, issue_* = 0, in_ready = 1, num_available = SIZE. A reset mid-operation discards all entries immediately.
- Dispatch of fully ready operands: issue_valid can assert on the cycle after the dispatch edge, so the minimum dispatch→issue latency is 1.
- CDB wakeup at edge t: the entry is issuable in cycle t+1. There is no same-cycle wakeup-to-issue.
- Issue accepted at edge t: num_available increments in cycle t+1.
- Full: num_available = 0 and in_ready = 0 until an issue handshake or flush. A full station with the oldest entry issuing shows in_ready = 1 only in the following cycle.
- issue_ready held low: the selected entry is held stably. Younger entries that become ready do not displace it.

## Test plan
- Reset then dispatch tag 3, op 2, v1 = 5, v2 = 7, both non-busy → cycle+1: issue_valid = 1, issue_tag = 3, issue_v1 = 5, issue_v2 = 7. With issue_ready = 1, num_available returns to 8.
- Dispatch tags 1, 2, 3, all ready, with issue_ready = 0, then raise issue_ready → issue order is 1, 2, 3. Repeat with tag 1 busy on q1 = 9: order is 2, 3, then 1 after a CDB broadcast of tag 9 with data 0xAB, and issue_v1 = 0xAB.
- Dispatch busy q2 = 6 in the same cycle that cdb_tag[1] = 6 with data 0x1234 → the entry is ready next cycle with issue_v2 = 0x1234.
- Fill all 8 entries with busy operands → in_ready = 0 and a 9th dispatch is ignored. Broadcast the tag of one entry and accept its issue → in_ready = 1 the cycle after the handshake.
- Two CDB ports broadcast different tags that wake the r1 and r2 of one entry simultaneously → both captured and the entry issues next cycle. The same tag on both ports with data 0x11 on port 0 and 0x22 on port 1 → 0x11 is captured.
- With 5 valid entries, assert flush together with in_valid → the next cycle has num_available = 8, issue_valid = 0, and no dispatched entry. Deassert rst mid-stream → all outputs are at reset values immediately.
